// File: rtl/capture_pkg.sv
// Shared definitions for the ADC capture path: state encoding, default word
// width, sample width and a saturating counter helper.
package capture_pkg;

    localparam int unsigned IN_W_DEF = 64;
    localparam int unsigned SAMPLE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } cap_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever empty is low; rd_data reads as zero while empty. A write
// into a full FIFO is accepted when a read happens in the same cycle.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Flags, qualified strobes and the fall-through read port.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    // Pointer update; clr flushes the contents without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; data is only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (do_wr && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/adc_stream_packer.sv
// Packs pairs of free-running ADC words into double-width beats, buffers them
// in a FWFT FIFO and streams them to the DMA under a small arm/trigger FSM.
module adc_stream_packer
    import capture_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned IN_W       = IN_W_DEF
) (
    input  logic              axi_aclk,
    input  logic              axi_rstb,
    input  logic [IN_W-1:0]   s_adc_tdata,
    input  logic              s_adc_tvalid,
    output logic [2*IN_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              arm,
    input  logic              soft_reset,
    input  logic              trig_mode,
    input  logic              trig_in,
    input  logic [31:0]       cap_beats,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [31:0]       beat_count
);

    cap_state_t        state;
    cap_state_t        state_next;
    logic [31:0]       cap_lat;
    logic              trig_mode_lat;
    logic              trig_prev;
    logic              phase;
    logic              pend;
    logic [IN_W-1:0]   pack_lo;
    logic [2*IN_W-1:0] beat_reg;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_rd;
    logic              push;
    logic              drop;
    logic              formed_all;
    logic              accept;
    logic              accept_odd;
    logic              arm_ok;

    // Beat-path strobes. Words stop being accepted once the pushed beats plus
    // the beat waiting to be pushed cover the requested length, so no extra
    // word is taken while the last beat is still in flight.
    always_comb begin
        fifo_rd    = m_axis_tvalid && m_axis_tready;
        push       = pend && (!fifo_full || fifo_rd);
        drop       = pend && fifo_full && !fifo_rd;
        formed_all = ({1'b0, beat_count} + {32'd0, pend}) >= {1'b0, cap_lat};
        accept     = (state == ST_CAPTURE) && s_adc_tvalid && !formed_all
                     && !drop && !soft_reset;
        accept_odd = accept && phase;
    end

    // Next-state logic; soft_reset overrides every transition including arm.
    always_comb begin
        state_next = state;
        arm_ok     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_next = ST_ARMED;
                    arm_ok     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (cap_lat == '0)
                    state_next = ST_DONE;
                else if (!trig_mode_lat || (trig_in && !trig_prev))
                    state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (drop || (beat_count >= cap_lat)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (soft_reset) begin
            state_next = ST_IDLE;
            arm_ok     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge axi_aclk or negedge axi_rstb) begin
        if (!axi_rstb) state <= ST_IDLE;
        else           state <= state_next;
    end

    // Capture parameters, trigger history, beat counter and sticky overflow.
    always_ff @(posedge axi_aclk or negedge axi_rstb) begin
        if (!axi_rstb) begin
            cap_lat       <= '0;
            trig_mode_lat <= 1'b0;
            trig_prev     <= 1'b0;
            beat_count    <= '0;
            overflow      <= 1'b0;
        end else begin
            trig_prev <= trig_in;
            if (soft_reset) begin
                beat_count <= '0;
                overflow   <= 1'b0;
            end else if (arm_ok) begin
                cap_lat       <= cap_beats;
                trig_mode_lat <= trig_mode;
                beat_count    <= '0;
                overflow      <= 1'b0;
            end else begin
                if (push) beat_count <= sat_inc32(beat_count);
                if (drop) overflow   <= 1'b1;
            end
        end
    end

    // Word pairing: even word parks in pack_lo, odd word completes the beat
    // which is pushed to the FIFO on the following cycle.
    always_ff @(posedge axi_aclk or negedge axi_rstb) begin
        if (!axi_rstb) begin
            phase    <= 1'b0;
            pend     <= 1'b0;
            pack_lo  <= '0;
            beat_reg <= '0;
        end else begin
            pend <= accept_odd;
            if (soft_reset || (state != ST_CAPTURE)) phase <= 1'b0;
            else if (accept)                        phase <= ~phase;
            if (accept && !phase) pack_lo  <= s_adc_tdata;
            if (accept_odd)       beat_reg <= {s_adc_tdata, pack_lo};
        end
    end

    sync_fifo_fwft #(
        .WIDTH (2 * IN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (axi_aclk),
        .rst_n   (axi_rstb),
        .clr     (soft_reset),
        .wr_en   (push),
        .wr_data (beat_reg),
        .rd_en   (fifo_rd),
        .rd_data (m_axis_tdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Status outputs.
    always_comb begin
        m_axis_tvalid = !fifo_empty;
        busy          = (state != ST_IDLE) && (state != ST_DONE);
        done          = (state == ST_DONE);
    end

endmodule

// File: tb/tb_adc_stream_packer.sv
// Directed bench for adc_stream_packer: reset, immediate and triggered
// capture, overflow abort, random backpressure, soft reset and zero length.
module tb_adc_stream_packer;

    localparam int unsigned DEPTH = 16;

    logic         axi_aclk = 1'b0;
    logic         axi_rstb;
    logic [63:0]  s_adc_tdata;
    logic         s_adc_tvalid;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         arm;
    logic         soft_reset;
    logic         trig_mode;
    logic         trig_in;
    logic [31:0]  cap_beats;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [31:0]  beat_count;

    int unsigned  n_assert = 0;
    int unsigned  n_fail   = 0;
    logic [127:0] got[$];
    logic         stall_prev = 1'b0;
    logic [127:0] stall_data = '0;

    adc_stream_packer #(
        .FIFO_DEPTH (DEPTH),
        .IN_W       (64)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_rstb      (axi_rstb),
        .s_adc_tdata   (s_adc_tdata),
        .s_adc_tvalid  (s_adc_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .arm           (arm),
        .soft_reset    (soft_reset),
        .trig_mode     (trig_mode),
        .trig_in       (trig_in),
        .cap_beats     (cap_beats),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .beat_count    (beat_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_aclk);
        #1;
    endtask

    function automatic logic [63:0] mkword(input logic [7:0] tag, input int unsigned k);
        return {tag, 24'(k), 8'hC3 ^ tag, 24'(k * 3 + 1)};
    endfunction

    function automatic logic [127:0] mkbeat(input logic [7:0] tag, input int unsigned j);
        return {mkword(tag, 2 * j + 1), mkword(tag, 2 * j)};
    endfunction

    function automatic logic [127:0] got_at(input int unsigned j);
        return (j < got.size()) ? got[j] : '0;
    endfunction

    // Output collector plus stall-stability checks on the stream.
    always @(negedge axi_aclk) begin
        if (!axi_rstb) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("axis_hold_valid", 128'(m_axis_tvalid), 128'd1);
                check("axis_hold_data", m_axis_tdata, stall_data);
            end
            if (m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
            stall_prev = m_axis_tvalid && !m_axis_tready && !soft_reset;
            stall_data = m_axis_tdata;
        end
    end

    initial begin
        int unsigned k;
        int unsigned n0;
        logic        hit;

        axi_rstb      = 1'b1;
        s_adc_tdata   = '0;
        s_adc_tvalid  = 1'b0;
        m_axis_tready = 1'b0;
        arm           = 1'b0;
        soft_reset    = 1'b0;
        trig_mode     = 1'b0;
        trig_in       = 1'b0;
        cap_beats     = '0;
        #3 axi_rstb = 1'b0;
        #4;
        check("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
        check("rst_tdata", m_axis_tdata, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_overflow", 128'(overflow), 128'd0);
        check("rst_beat_count", 128'(beat_count), 128'd0);
        step();
        axi_rstb = 1'b1;
        step();

        // Immediate start, 4 beats, continuous words; cap_beats changed after arm.
        m_axis_tready = 1'b1;
        trig_mode     = 1'b0;
        cap_beats     = 32'd4;
        got.delete();
        arm = 1'b1;
        step();
        arm       = 1'b0;
        cap_beats = 32'd0;
        check("t1_busy_armed", 128'(busy), 128'd1);
        step();
        for (int unsigned i = 0; i < 12; i++) begin
            s_adc_tvalid = 1'b1;
            s_adc_tdata  = mkword(8'h11, i);
            if (i == 2) check("t1_lat_c2", 128'(m_axis_tvalid), 128'd0);
            if (i == 3) begin
                check("t1_lat_c3", 128'(m_axis_tvalid), 128'd1);
                check("t1_beat0_head", m_axis_tdata, mkbeat(8'h11, 0));
            end
            step();
        end
        s_adc_tvalid = 1'b0;
        for (int c = 0; c < 50 && !done; c++) step();
        check("t1_done", 128'(done), 128'd1);
        check("t1_overflow", 128'(overflow), 128'd0);
        check("t1_nbeats", 128'(got.size()), 128'd4);
        check("t1_beat_count", 128'(beat_count), 128'd4);
        for (int unsigned j = 0; j < 4; j++) check("t1_beat", got_at(j), mkbeat(8'h11, j));

        // Triggered start: high trig_in at arm is not an edge.
        trig_mode = 1'b1;
        cap_beats = 32'd2;
        trig_in   = 1'b1;
        step();
        got.delete();
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int unsigned c = 0; c < 20; c++) begin
            s_adc_tvalid = 1'b1;
            s_adc_tdata  = mkword(8'h2F, 100 + c);
            step();
        end
        check("t2_no_output", 128'(got.size()), 128'd0);
        check("t2_busy_wait", 128'(busy), 128'd1);
        check("t2_tvalid_wait", 128'(m_axis_tvalid), 128'd0);
        s_adc_tvalid = 1'b0;
        trig_in      = 1'b0;
        step();
        trig_in = 1'b1;
        step();
        for (int unsigned i = 0; i < 8; i++) begin
            s_adc_tvalid = 1'b1;
            s_adc_tdata  = mkword(8'h22, i);
            step();
        end
        s_adc_tvalid = 1'b0;
        trig_in      = 1'b0;
        for (int c = 0; c < 50 && !done; c++) step();
        check("t2_done", 128'(done), 128'd1);
        check("t2_nbeats", 128'(got.size()), 128'd2);
        for (int unsigned j = 0; j < 2; j++) check("t2_beat", got_at(j), mkbeat(8'h22, j));

        // Overflow abort with no backpressure relief.
        trig_mode     = 1'b0;
        cap_beats     = 32'd64;
        m_axis_tready = 1'b0;
        got.delete();
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        for (int unsigned i = 0; i < 40; i++) begin
            s_adc_tvalid = 1'b1;
            s_adc_tdata  = mkword(8'h33, i);
            step();
        end
        s_adc_tvalid = 1'b0;
        repeat (4) step();
        check("t3_overflow", 128'(overflow), 128'd1);
        check("t3_beat_count", 128'(beat_count), 128'd16);
        check("t3_busy_drain", 128'(busy), 128'd1);
        check("t3_not_done", 128'(done), 128'd0);
        check("t3_tvalid", 128'(m_axis_tvalid), 128'd1);
        m_axis_tready = 1'b1;
        for (int c = 0; c < 60 && !done; c++) step();
        check("t3_done", 128'(done), 128'd1);
        check("t3_nbeats", 128'(got.size()), 128'd16);
        check("t3_overflow_sticky", 128'(overflow), 128'd1);
        for (int unsigned j = 0; j < 16; j++) check("t3_beat", got_at(j), mkbeat(8'h33, j));

        // Random backpressure, bursty source (24 valid / 16 idle per 40).
        cap_beats = 32'd100;
        got.delete();
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        k = 0;
        for (int unsigned c = 0; c < 3000 && !done; c++) begin
            s_adc_tvalid  = ((c % 40) < 24);
            s_adc_tdata   = mkword(8'h44, k);
            if ((c % 40) < 24) k++;
            m_axis_tready = 1'($urandom_range(0, 1));
            step();
        end
        s_adc_tvalid  = 1'b0;
        m_axis_tready = 1'b1;
        check("t4_done", 128'(done), 128'd1);
        check("t4_overflow", 128'(overflow), 128'd0);
        check("t4_nbeats", 128'(got.size()), 128'd100);
        check("t4_beat_count", 128'(beat_count), 128'd100);
        for (int unsigned j = 0; j < 100; j++) check("t4_beat", got_at(j), mkbeat(8'h44, j));

        // Soft reset together with arm in the middle of a capture.
        cap_beats = 32'd50;
        got.delete();
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        k   = 0;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            s_adc_tvalid = 1'b1;
            s_adc_tdata  = mkword(8'h55, k);
            k++;
            step();
            hit = (beat_count == 32'd10);
        end
        check("t5_reached_10", 128'(hit), 128'd1);
        soft_reset = 1'b1;
        arm        = 1'b1;
        cap_beats  = 32'd5;
        step();
        soft_reset = 1'b0;
        arm        = 1'b0;
        check("t5_busy", 128'(busy), 128'd0);
        check("t5_done", 128'(done), 128'd0);
        check("t5_tvalid", 128'(m_axis_tvalid), 128'd0);
        check("t5_beat_count", 128'(beat_count), 128'd0);
        check("t5_overflow", 128'(overflow), 128'd0);
        n0 = got.size();
        repeat (10) step();
        s_adc_tvalid = 1'b0;
        check("t5_idle_busy", 128'(busy), 128'd0);
        check("t5_idle_tvalid", 128'(m_axis_tvalid), 128'd0);
        check("t5_no_more_beats", 128'(got.size()), 128'(n0));

        // Zero-length capture.
        cap_beats = 32'd0;
        got.delete();
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("t6_armed_busy", 128'(busy), 128'd1);
        check("t6_armed_not_done", 128'(done), 128'd0);
        step();
        check("t6_done", 128'(done), 128'd1);
        check("t6_busy", 128'(busy), 128'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            s_adc_tvalid = 1'b1;
            s_adc_tdata  = mkword(8'h66, i);
            step();
        end
        s_adc_tvalid = 1'b0;
        check("t6_nbeats", 128'(got.size()), 128'd0);
        check("t6_beat_count", 128'(beat_count), 128'd0);

        // Asynchronous reset with beats buffered mid-capture.
        cap_beats     = 32'd8;
        m_axis_tready = 1'b0;
        got.delete();
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        for (int unsigned i = 0; i < 10; i++) begin
            s_adc_tvalid = 1'b1;
            s_adc_tdata  = mkword(8'h77, i);
            step();
        end
        check("t7_buffered", 128'(m_axis_tvalid), 128'd1);
        #2 axi_rstb = 1'b0;
        #1;
        check("t7_rst_tvalid", 128'(m_axis_tvalid), 128'd0);
        check("t7_rst_tdata", m_axis_tdata, 128'd0);
        check("t7_rst_busy", 128'(busy), 128'd0);
        check("t7_rst_beat_count", 128'(beat_count), 128'd0);
        step();
        step();
        axi_rstb      = 1'b1;
        m_axis_tready = 1'b1;
        repeat (20) step();
        s_adc_tvalid = 1'b0;
        check("t7_no_output", 128'(got.size()), 128'd0);
        check("t7_tvalid", 128'(m_axis_tvalid), 128'd0);
        check("t7_idle", 128'(busy | done), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
